pds_rx_port: RTL

- Ingress stage of the switch DUT. It sits directly downstream of the pds_if packet driver and consumes the byte stream that one port's driver puts on the interface.
- It parses and checks each packet: framing, length and parity.
- Good packets are buffered store-and-forward in a byte FIFO and presented to the switch core with a valid/ready handshake. Bad packets are erased from the FIFO and never reach the core.

---
 rtl/pds_rx_port.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pds_rx_port.sv
// Ingress port: parses header/length/payload/parity packets, buffers good packets
// store-and-forward in a byte FIFO and drops bad ones by rewinding the write pointer.
module pds_rx_port #(
    parameter int unsigned PORTNO  = 0,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_suspend,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  out_port,
    output logic        err_parity,
    output logic        err_len,
    output logic        err_ovf,
    output logic [15:0] pkt_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {StIdle, StLen, StPayload, StParity, StDiscard} state_e;

    state_e        state_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, commit_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    xor_q;
    logic [15:0]   pkt_count_q;
    logic          in_suspend_q, err_parity_q, err_len_q, err_ovf_q;
    logic [9:0]    mem_q [DEPTH];

    logic          full, len_bad, wr_en, rd_fire;
    logic [9:0]    wr_word, head;
    logic [PW-1:0] used;

    // One slot is kept empty so that wr_ptr == rd_ptr always means empty.
    assign full    = (wr_ptr_q + PW'(1)) == rd_ptr_q;
    assign len_bad = (in_data == 8'd0) || (32'(in_data) > MAX_LEN);
    assign used    = wr_ptr_q - rd_ptr_q;

    assign out_valid = rd_ptr_q != commit_ptr_q;
    assign rd_fire   = out_valid && out_ready;
    assign head      = out_valid ? mem_q[rd_ptr_q] : 10'd0;
    assign out_sop   = head[9];
    assign out_eop   = head[8];
    assign out_data  = head[7:0];

    assign out_port   = 4'(PORTNO);
    assign in_suspend = in_suspend_q;
    assign err_parity = err_parity_q;
    assign err_len    = err_len_q;
    assign err_ovf    = err_ovf_q;
    assign pkt_count  = pkt_count_q;

    always_comb begin
        wr_en   = 1'b0;
        wr_word = {2'b00, in_data};
        unique case (state_q)
            StIdle: begin
                wr_en   = in_valid;
                wr_word = {2'b10, in_data};
            end
            StLen:     wr_en = in_valid && !len_bad;
            StPayload: begin
                wr_en   = in_valid;
                wr_word = {1'b0, cnt_q == CW'(1), in_data};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en && !full) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            cnt_q        <= '0;
            xor_q        <= '0;
            pkt_count_q  <= '0;
            in_suspend_q <= 1'b0;
            err_parity_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            err_parity_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            in_suspend_q <= (DEPTH - 1 - 32'(used)) < (MAX_LEN + 2);
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (full) begin
                            err_ovf_q <= 1'b1;
                            state_q   <= StDiscard;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                            xor_q    <= in_data;
                            state_q  <= StLen;
                        end
                    end
                end
                StLen: begin
                    if (!in_valid) begin
                        wr_ptr_q  <= commit_ptr_q;
                        err_len_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (len_bad) begin
                        wr_ptr_q  <= commit_ptr_q;
                        err_len_q <= 1'b1;
                        state_q   <= StDiscard;
                    end else if (full) begin
                        wr_ptr_q  <= commit_ptr_q;
                        err_ovf_q <= 1'b1;
                        state_q   <= StDiscard;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        xor_q    <= xor_q ^ in_data;
                        cnt_q    <= in_data[CW-1:0];
                        state_q  <= StPayload;
                    end
                end
                StPayload: begin
                    if (!in_valid) begin
                        wr_ptr_q  <= commit_ptr_q;
                        err_len_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (full) begin
                        wr_ptr_q  <= commit_ptr_q;
                        err_ovf_q <= 1'b1;
                        state_q   <= StDiscard;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        xor_q    <= xor_q ^ in_data;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= StParity;
                        end
                    end
                end
                StParity: begin
                    if (!in_valid) begin
                        wr_ptr_q  <= commit_ptr_q;
                        err_len_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        if (in_data == xor_q) begin
                            commit_ptr_q <= wr_ptr_q;
                            pkt_count_q  <= pkt_count_q + 16'd1;
                        end else begin
                            wr_ptr_q     <= commit_ptr_q;
                            err_parity_q <= 1'b1;
                        end
                        // Returns to idle on the following low cycle; a still-high
                        // in_valid there is treated as garbage and discarded.
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    wr_ptr_q <= commit_ptr_q;
                    if (!in_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
